msrv32_wb_port_arbiter: RTL and testbench

//  Arbiter for the single integer register-file write port. Two sources

---
 rtl/msrv32_pkg.sv | 14 +
 rtl/msrv32_starve_cnt.sv | 30 +++
 rtl/msrv32_wb_port_arbiter.sv | 89 ++++++++
 tb/tb_msrv32_wb_port_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 register-file writeback path.
package msrv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P    = 2'd1,
    GNT_L    = 2'd2
  } wb_grant_e;

endpackage

// File: rtl/msrv32_starve_cnt.sv
// Counts cycles a valid long-latency result waits without a grant; raises
// force_out once it has waited MAX_WAIT cycles.
module msrv32_starve_cnt #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic l_valid_in,
  input  logic l_ready_in,
  output logic force_out
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wait_cnt <= '0;
    end else if (!l_valid_in || l_ready_in) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != CNT_MAX) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign force_out = l_valid_in & (r_wait_cnt == CNT_MAX);

endmodule

// File: rtl/msrv32_wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback (P)
// and long-latency completion (L), with flush gating and starvation relief.
module msrv32_wb_port_arbiter
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN     = msrv32_pkg::XLEN,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            flush_in,
  input  logic            p_wr_en_in,
  input  logic [4:0]      p_rd_addr_in,
  input  logic [XLEN-1:0] p_rd_data_in,
  input  logic            p_csr_wr_en_in,
  input  logic            l_valid_in,
  input  logic [4:0]      l_rd_addr_in,
  input  logic [XLEN-1:0] l_rd_data_in,
  output logic            l_ready_out,
  output logic            stall_out,
  output logic            rf_wr_en_out,
  output logic [4:0]      rf_wr_addr_out,
  output logic [XLEN-1:0] rf_wr_data_out,
  output logic            csr_wr_en_out
);

  wb_grant_e              w_grant;
  logic                   w_p_req;
  logic                   w_force;
  logic [REG_ADDR_W-1:0]  w_sel_addr;
  logic [XLEN-1:0]        w_sel_data;

  assign w_p_req = p_wr_en_in & ~flush_in;

  msrv32_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .l_valid_in (l_valid_in),
    .l_ready_in (l_ready_out),
    .force_out  (w_force)
  );

  // A forced L grant takes priority over P; otherwise P wins whenever it asks.
  always_comb begin
    w_grant = GNT_NONE;
    if (!rst_in) begin
      if (w_force && w_p_req) begin
        w_grant = GNT_L;
      end else if (w_p_req) begin
        w_grant = GNT_P;
      end else if (l_valid_in) begin
        w_grant = GNT_L;
      end
    end
  end

  assign l_ready_out = (w_grant == GNT_L);
  assign stall_out   = (w_grant == GNT_L) & w_p_req;

  always_comb begin
    w_sel_addr = p_rd_addr_in;
    w_sel_data = p_rd_data_in;
    if (w_grant == GNT_L) begin
      w_sel_addr = l_rd_addr_in;
      w_sel_data = l_rd_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rf_wr_en_out   <= 1'b0;
      rf_wr_addr_out <= '0;
      rf_wr_data_out <= '0;
      csr_wr_en_out  <= 1'b0;
    end else begin
      csr_wr_en_out <= p_csr_wr_en_in & ~flush_in & ~stall_out;
      if (w_grant != GNT_NONE) begin
        rf_wr_en_out   <= (w_sel_addr != REG_X0);
        rf_wr_addr_out <= w_sel_addr;
        rf_wr_data_out <= w_sel_data;
      end else begin
        rf_wr_en_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_wb_port_arbiter.sv
// Directed checks of the writeback port arbiter with hand-computed expectations.
module tb_msrv32_wb_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        p_wr_en_in;
  logic [4:0]  p_rd_addr_in;
  logic [31:0] p_rd_data_in;
  logic        p_csr_wr_en_in;
  logic        l_valid_in;
  logic [4:0]  l_rd_addr_in;
  logic [31:0] l_rd_data_in;
  logic        l_ready_out;
  logic        stall_out;
  logic        rf_wr_en_out;
  logic [4:0]  rf_wr_addr_out;
  logic [31:0] rf_wr_data_out;
  logic        csr_wr_en_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  msrv32_wb_port_arbiter #(
    .XLEN     (32),
    .MAX_WAIT (4)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_in       (flush_in),
    .p_wr_en_in     (p_wr_en_in),
    .p_rd_addr_in   (p_rd_addr_in),
    .p_rd_data_in   (p_rd_data_in),
    .p_csr_wr_en_in (p_csr_wr_en_in),
    .l_valid_in     (l_valid_in),
    .l_rd_addr_in   (l_rd_addr_in),
    .l_rd_data_in   (l_rd_data_in),
    .l_ready_out    (l_ready_out),
    .stall_out      (stall_out),
    .rf_wr_en_out   (rf_wr_en_out),
    .rf_wr_addr_out (rf_wr_addr_out),
    .rf_wr_data_out (rf_wr_data_out),
    .csr_wr_en_out  (csr_wr_en_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_in = 1'b1;
    flush_in = 1'b0;
    p_wr_en_in = 1'b0;
    p_rd_addr_in = '0;
    p_rd_data_in = '0;
    p_csr_wr_en_in = 1'b0;
    l_valid_in = 1'b0;
    l_rd_addr_in = '0;
    l_rd_data_in = '0;
    step();
    step();
    rst_in = 1'b0;
    settle();

    // reset state
    check("rst_en",    rf_wr_en_out, 0);
    check("rst_addr",  rf_wr_addr_out, 0);
    check("rst_data",  rf_wr_data_out, 0);
    check("rst_csr",   csr_wr_en_out, 0);
    check("rst_lrdy",  l_ready_out, 0);
    check("rst_stall", stall_out, 0);
    check("rst_cnt",   dut.u_starve_cnt.r_wait_cnt, 0);

    // plain P write with CSR write
    p_wr_en_in = 1'b1; p_rd_addr_in = 5'd5; p_rd_data_in = 32'hDEADBEEF;
    p_csr_wr_en_in = 1'b1;
    settle();
    check("p_lrdy",  l_ready_out, 0);
    check("p_stall", stall_out, 0);
    step();
    check("p_en",   rf_wr_en_out, 1);
    check("p_addr", rf_wr_addr_out, 5);
    check("p_data", rf_wr_data_out, 32'hDEADBEEF);
    check("p_csr",  csr_wr_en_out, 1);

    // asynchronous reset while L is being granted
    p_wr_en_in = 1'b0; p_csr_wr_en_in = 1'b0;
    l_valid_in = 1'b1; l_rd_addr_in = 5'd7; l_rd_data_in = 32'h0000_0077;
    settle();
    check("ar_lrdy_pre", l_ready_out, 1);
    rst_in = 1'b1;
    settle();
    check("ar_en",   rf_wr_en_out, 0);
    check("ar_addr", rf_wr_addr_out, 0);
    check("ar_data", rf_wr_data_out, 0);
    check("ar_csr",  csr_wr_en_out, 0);
    check("ar_lrdy", l_ready_out, 0);
    step();
    check("ar_hold_en", rf_wr_en_out, 0);
    rst_in = 1'b0;
    settle();
    check("ar_regrant", l_ready_out, 1);
    step();
    check("ar_l_en",   rf_wr_en_out, 1);
    check("ar_l_addr", rf_wr_addr_out, 7);
    check("ar_l_data", rf_wr_data_out, 32'h77);
    l_valid_in = 1'b0;

    // flush kills the P write and CSR write; write port holds address/data
    flush_in = 1'b1; p_wr_en_in = 1'b1; p_csr_wr_en_in = 1'b1;
    p_rd_addr_in = 5'd9; p_rd_data_in = 32'h9999_9999;
    settle();
    check("fl_lrdy",  l_ready_out, 0);
    check("fl_stall", stall_out, 0);
    step();
    check("fl_en",   rf_wr_en_out, 0);
    check("fl_csr",  csr_wr_en_out, 0);
    check("fl_addr", rf_wr_addr_out, 7);
    check("fl_data", rf_wr_data_out, 32'h77);
    flush_in = 1'b0;

    // starvation: P and L both request continuously
    p_wr_en_in = 1'b1; p_csr_wr_en_in = 1'b1; p_rd_addr_in = 5'd3;
    l_valid_in = 1'b1; l_rd_addr_in = 5'd12; l_rd_data_in = 32'h0000_CAFE;
    for (int i = 0; i < 4; i++) begin
      p_rd_data_in = 32'h100 + 32'(i);
      settle();
      check($sformatf("sv_lrdy%0d", i), l_ready_out, 0);
      check($sformatf("sv_stall%0d", i), stall_out, 0);
      step();
      check($sformatf("sv_en%0d", i), rf_wr_en_out, 1);
      check($sformatf("sv_addr%0d", i), rf_wr_addr_out, 3);
      check($sformatf("sv_data%0d", i), rf_wr_data_out, 32'h100 + 32'(i));
      check($sformatf("sv_csr%0d", i), csr_wr_en_out, 1);
      check($sformatf("sv_cnt%0d", i), dut.u_starve_cnt.r_wait_cnt, 64'(i + 1));
    end
    p_rd_data_in = 32'h104;
    settle();
    check("sv_force_lrdy",  l_ready_out, 1);
    check("sv_force_stall", stall_out, 1);
    step();
    check("sv_l_en",   rf_wr_en_out, 1);
    check("sv_l_addr", rf_wr_addr_out, 12);
    check("sv_l_data", rf_wr_data_out, 32'hCAFE);
    check("sv_l_csr",  csr_wr_en_out, 0);
    check("sv_l_cnt",  dut.u_starve_cnt.r_wait_cnt, 0);
    l_valid_in = 1'b0;
    settle();
    check("sv_p_resume_stall", stall_out, 0);
    step();
    check("sv_p_resume_addr", rf_wr_addr_out, 3);
    check("sv_p_resume_data", rf_wr_data_out, 32'h104);
    check("sv_p_resume_csr",  csr_wr_en_out, 1);

    // L write to x0 completes handshake without enabling the write
    p_wr_en_in = 1'b0; p_csr_wr_en_in = 1'b0;
    l_valid_in = 1'b1; l_rd_addr_in = 5'd0; l_rd_data_in = 32'h0000_1234;
    settle();
    check("x0_lrdy",  l_ready_out, 1);
    check("x0_stall", stall_out, 0);
    step();
    check("x0_en",   rf_wr_en_out, 0);
    check("x0_addr", rf_wr_addr_out, 0);
    check("x0_data", rf_wr_data_out, 32'h1234);
    l_valid_in = 1'b0;

    // L waits two cycles behind P, then a flush releases it
    p_wr_en_in = 1'b1; p_rd_addr_in = 5'd4; p_rd_data_in = 32'h44;
    l_valid_in = 1'b1; l_rd_addr_in = 5'd15; l_rd_data_in = 32'h0000_F00D;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("fw_lrdy%0d", i), l_ready_out, 0);
      step();
      check($sformatf("fw_addr%0d", i), rf_wr_addr_out, 4);
      check($sformatf("fw_cnt%0d", i), dut.u_starve_cnt.r_wait_cnt, 64'(i + 1));
    end
    flush_in = 1'b1; p_csr_wr_en_in = 1'b1;
    settle();
    check("fw_flush_lrdy",  l_ready_out, 1);
    check("fw_flush_stall", stall_out, 0);
    step();
    check("fw_l_en",   rf_wr_en_out, 1);
    check("fw_l_addr", rf_wr_addr_out, 15);
    check("fw_l_data", rf_wr_data_out, 32'hF00D);
    check("fw_l_csr",  csr_wr_en_out, 0);
    check("fw_l_cnt",  dut.u_starve_cnt.r_wait_cnt, 0);
    flush_in = 1'b0; p_wr_en_in = 1'b0; p_csr_wr_en_in = 1'b0; l_valid_in = 1'b0;
    step();
    check("idle_en",   rf_wr_en_out, 0);
    check("idle_addr", rf_wr_addr_out, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
